// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display: FSM states, digit
// position codes, 7-segment patterns and the double-dabble adjust step.
package alu_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_e;

    localparam logic [1:0] DIG_HUNDREDS = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_ONES     = 2'd2;
    localparam logic [1:0] DIG_GAP      = 2'd3;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Double-dabble pre-shift correction: any BCD nibble >= 5 gets +3.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] res;
        res = bcd;
        for (int n = 0; n < 3; n++) begin
            if (res[n*4 +: 4] >= 4'd5) begin
                res[n*4 +: 4] = res[n*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment pattern (bit0=a .. bit6=g); purely combinational.
// Codes 10..15 never occur in valid BCD and decode to blank.
module seg7_decode
    import alu_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_result_seg7_display.sv
// Captures an 8-bit ALU result, converts it to BCD over 8 cycles, then cycles
// hundreds/tens/ones/gap on one 7-segment display, DWELL_CYCLES per position.
module alu_result_seg7_display
    import alu_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 12_500_000,
    parameter int DWELL_W      = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] result_in,
    input  logic       result_valid,
    output logic       busy,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [1:0] digit_idx
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_e             state_q, state_d;
    logic [7:0]         bin_q, bin_d;
    logic [11:0]        bcd_q, bcd_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         digit_idx_q, digit_idx_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               busy_q, busy_d;
    logic [3:0]         digit_sel;
    logic [6:0]         digit_seg;
    logic [11:0]        bcd_adj;

    assign bcd_adj = bcd_adjust(bcd_q);

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        bit_cnt_d   = bit_cnt_q;
        dwell_d     = dwell_q;
        digit_idx_d = digit_idx_q;

        case (state_q)
            ST_CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
                bit_cnt_d      = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d     = ST_SHOW;
                    dwell_d     = '0;
                    digit_idx_d = DIG_HUNDREDS;
                end
            end
            ST_SHOW: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d     = '0;
                    digit_idx_d = digit_idx_q + 2'd1;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: ;
        endcase

        // A new result is only accepted outside CONVERT; it overrides SHOW.
        if (result_valid && state_q != ST_CONVERT) begin
            state_d     = ST_CONVERT;
            bin_d       = result_in;
            bcd_d       = '0;
            bit_cnt_d   = '0;
            dwell_d     = '0;
            digit_idx_d = DIG_HUNDREDS;
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        case (digit_idx_d)
            DIG_HUNDREDS: digit_sel = bcd_d[11:8];
            DIG_TENS:     digit_sel = bcd_d[7:4];
            DIG_ONES:     digit_sel = bcd_d[3:0];
            default:      digit_sel = 4'd0;
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd_i (digit_sel),
        .seg_o (digit_seg)
    );

    // Outputs are computed from next-state so the registered values line up
    // with the state they describe.
    always_comb begin
        busy_d = (state_d == ST_CONVERT);
        seg_d  = SEG_BLANK;
        dp_d   = 1'b0;
        if (state_d == ST_SHOW) begin
            seg_d = (digit_idx_d == DIG_GAP) ? SEG_BLANK : digit_seg;
            dp_d  = (digit_idx_d == DIG_ONES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            bit_cnt_q   <= '0;
            dwell_q     <= '0;
            digit_idx_q <= DIG_HUNDREDS;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            bit_cnt_q   <= bit_cnt_d;
            dwell_q     <= dwell_d;
            digit_idx_q <= digit_idx_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign seg_out   = seg_q;
    assign dp_out    = dp_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_alu_result_seg7_display.sv
// Bench for alu_result_seg7_display with a short dwell; expected digits come from
// decimal arithmetic on the captured value and a segment lookup table.
module tb_alu_result_seg7_display;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] result_in = 8'd0;
    logic       result_valid = 1'b0;
    logic       busy;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [1:0] digit_idx;

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0] segtab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    alu_result_seg7_display #(.DWELL_CYCLES(DW), .DWELL_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .result_in    (result_in),
        .result_valid (result_valid),
        .busy         (busy),
        .seg_out      (seg_out),
        .dp_out       (dp_out),
        .digit_idx    (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dark(input string tag, input logic exp_busy);
        chk({tag, ".seg"},  {1'b0, seg_out}, 8'h00);
        chk({tag, ".dp"},   {7'd0, dp_out}, 8'h00);
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, exp_busy});
    endtask

    // Expected display k cycles after the first digit appeared.
    task automatic chk_show(input string tag, input int v, input int k);
        int pos;
        int dig [0:2];
        logic [6:0] exp_seg;
        pos = (k / DW) % 4;
        dig[0] = v / 100;
        dig[1] = (v / 10) % 10;
        dig[2] = v % 10;
        exp_seg = (pos == 3) ? 7'h00 : segtab[dig[pos]];
        chk({tag, ".seg"},  {1'b0, seg_out}, {1'b0, exp_seg});
        chk({tag, ".idx"},  {6'd0, digit_idx}, 8'(pos));
        chk({tag, ".dp"},   {7'd0, dp_out}, {7'd0, pos == 2});
        chk({tag, ".busy"}, {7'd0, busy}, 8'h00);
    endtask

    // Strobe v, check 8 busy cycles, then ncyc display cycles.
    // With inject set, a second strobe (0x05) is issued mid-conversion.
    task automatic run_value(input string tag, input int v, input int ncyc, input bit inject);
        result_in = 8'(v);
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_dark({tag, ".conv"}, 1'b1);
            if (inject && i == 2) begin
                result_in = 8'h05;
                result_valid = 1'b1;
            end
            step();
            result_valid = 1'b0;
        end
        for (int k = 0; k < ncyc; k++) begin
            chk_show(tag, v, k);
            step();
        end
    endtask

    initial begin
        int v;
        #1;
        chk_dark("reset", 1'b0);
        chk("reset.idx", {6'd0, digit_idx}, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_dark("idle", 1'b0);
            step();
        end

        run_value("ff", 255, 20, 1'b0);
        run_value("00", 0, 18, 1'b0);
        run_value("2a", 42, 18, 1'b0);
        run_value("7b", 123, 14, 1'b1);
        run_value("05", 5, 18, 1'b0);

        // Reset during the 4th conversion cycle.
        result_in = 8'd200;
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #2;
        chk_dark("rstmid", 1'b0);
        chk("rstmid.idx", {6'd0, digit_idx}, 8'h00);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk_dark("postrst", 1'b0);
            chk("postrst.idx", {6'd0, digit_idx}, 8'h00);
            step();
        end

        // Freeze mid-display with enable low.
        v = 87;
        run_value("frz", v, 6, 1'b0);
        ena = 1'b0;
        result_in = 8'h11;
        result_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_show("frozen", v, 6);
            step();
        end
        result_valid = 1'b0;
        ena = 1'b1;
        for (int k = 6; k < 22; k++) begin
            chk_show("resume", v, k);
            step();
        end

        for (int r = 0; r < 6; r++) begin
            v = int'($urandom_range(0, 255));
            run_value("rand", v, 17, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
